// File: rtl/m_st7789_rx_pkg.sv
// Shared definitions for the ST7789 receive model.
// Holds the command opcodes the decoder reacts to, the decoder state type
// and the default geometry/idle parameters.
package m_st7789_rx_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int DEF_WIDTH    = 240;
    localparam int DEF_HEIGHT   = 240;
    localparam int DEF_IDLE_CYC = 3;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_CASET,
        ST_RASET,
        ST_SKIP,
        ST_PIX_HI,
        ST_PIX_LO
    } state_e;

endpackage

// File: rtl/m_st7789_rx_deser.sv
// Serial-to-byte deserialiser for the ST7789 link.
// SCL/SDA/DC pass identical 2-flop synchronisers, so their relative timing is
// preserved. A bit is taken on each synced SCL falling edge, MSB first. DC is
// captured together with the eighth bit. A partial byte (1..7 bits) followed by
// IDLE_CYC consecutive synced SCL-high samples is discarded and flagged.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset (synchronisers and datapath)
//   srst_i      synchronous active-high soft reset (datapath only)
//   scl_i       serial clock, idles high, asynchronous
//   sda_i       serial data, asynchronous
//   dc_i        data/command select, asynchronous
//   byte_vld_o  1-cycle pulse: byte_o/dc_o valid
//   byte_o      received byte
//   dc_o        DC level sampled with the last bit of the byte
//   trunc_o     1-cycle pulse: partial byte dropped by idle timeout
module m_st7789_rx_deser
    import m_st7789_rx_pkg::*;
#(
    parameter int IDLE_CYC = DEF_IDLE_CYC
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       srst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       dc_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       dc_o,
    output logic       trunc_o
);

    localparam int IW = (IDLE_CYC < 2) ? 1 : $clog2(IDLE_CYC + 1);

    logic [1:0]    scl_sync_q;
    logic [1:0]    sda_sync_q;
    logic [1:0]    dc_sync_q;
    logic          scl_prev_q;
    logic          fall_q;
    logic          bit_q;
    logic          dcb_q;

    logic [7:0]    shift_q, shift_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          dc_q, dc_d;
    logic          vld_q, vld_d;
    logic          trunc_q, trunc_d;
    logic [IW-1:0] idle_q, idle_d;

    logic          scl_s;

    assign scl_s = scl_sync_q[1];

    // Synchroniser chain plus one registered edge stage. SCL resets high so a
    // reset release never looks like a falling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b00;
            dc_sync_q  <= 2'b00;
            scl_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b0;
            dcb_q      <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            dc_sync_q  <= {dc_sync_q[0], dc_i};
            scl_prev_q <= scl_s;
            fall_q     <= scl_prev_q & ~scl_s;
            bit_q      <= sda_sync_q[1];
            dcb_q      <= dc_sync_q[1];
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        dc_d    = dc_q;
        vld_d   = 1'b0;
        trunc_d = 1'b0;
        idle_d  = idle_q;

        // Down-counter of consecutive high samples; reloaded whenever SCL is low.
        if (!scl_s) begin
            idle_d = IW'(IDLE_CYC);
        end else if (idle_q != '0) begin
            idle_d = idle_q - 1'b1;
        end

        if (fall_q) begin
            shift_d = {shift_q[6:0], bit_q};
            if (cnt_q == 3'd7) begin
                cnt_d  = 3'd0;
                byte_d = {shift_q[6:0], bit_q};
                dc_d   = dcb_q;
                vld_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end else if (scl_s && (idle_q == IW'(1)) && (cnt_q != 3'd0)) begin
            // Terminal count reached with a partial byte held: resync.
            cnt_d   = 3'd0;
            trunc_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || srst_i) begin
            shift_q <= 8'h00;
            cnt_q   <= 3'd0;
            byte_q  <= 8'h00;
            dc_q    <= 1'b0;
            vld_q   <= 1'b0;
            trunc_q <= 1'b0;
            idle_q  <= IW'(IDLE_CYC);
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            dc_q    <= dc_d;
            vld_q   <= vld_d;
            trunc_q <= trunc_d;
            idle_q  <= idle_d;
        end
    end

    assign byte_vld_o = vld_q;
    assign byte_o     = byte_q;
    assign dc_o       = dc_q;
    assign trunc_o    = trunc_q;

endmodule

// File: rtl/m_st7789_rx.sv
// ST7789 SPI receive model.
// Decodes command/parameter bytes, tracks the CASET/RASET window and emits
// {y,x}-addressed RGB565 pixel writes from RAMWR streams.
// Ports:
//   w_clk, w_rst          system clock, synchronous active-high reset
//   st7789_SCL/SDA/DC     serial link pins (asynchronous)
//   st7789_RES            display reset, active low, asynchronous
//   w_cmd_vld / w_cmd     command pulse / last opcode (held)
//   w_we/w_wadr/w_wdata   pixel write strobe, {y,x} address, RGB565 data
//   w_frame_done          pulses with the (XE,YE) pixel slot
//   w_err                 sticky partial-byte flag, cleared by w_rst only
//
// state     | meaning
// ST_CMD    | waiting for a command, data bytes ignored
// ST_CASET  | collecting 4 column-window params
// ST_RASET  | collecting 4 row-window params
// ST_SKIP   | ignoring params until the next command
// ST_PIX_HI | expecting pixel high byte
// ST_PIX_LO | expecting pixel low byte, then write
module m_st7789_rx
    import m_st7789_rx_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int IDLE_CYC = DEF_IDLE_CYC
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        st7789_SCL,
    input  logic        st7789_SDA,
    input  logic        st7789_DC,
    input  logic        st7789_RES,
    output logic        w_cmd_vld,
    output logic [7:0]  w_cmd,
    output logic        w_we,
    output logic [15:0] w_wadr,
    output logic [15:0] w_wdata,
    output logic        w_frame_done,
    output logic        w_err
);

    localparam logic [15:0] W16    = 16'(WIDTH);
    localparam logic [15:0] H16    = 16'(HEIGHT);
    localparam logic [15:0] XE_RST = 16'(WIDTH - 1);
    localparam logic [15:0] YE_RST = 16'(HEIGHT - 1);

    logic [1:0]  res_sync_q;
    logic        srst;

    logic        rx_vld;
    logic [7:0]  rx_byte;
    logic        rx_dc;
    logic        rx_trunc;

    state_e      state_q, state_d;
    logic [1:0]  pidx_q, pidx_d;
    logic [23:0] par_q, par_d;
    logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0] cx_q, cx_d, cy_q, cy_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_vld_q, cmd_vld_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        we_q, we_d;
    logic [15:0] wadr_q, wadr_d, wdata_q, wdata_d;
    logic        fd_q, fd_d;
    logic        err_q, err_d;

    logic [15:0] win_s, win_e_raw, win_e;

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            res_sync_q <= 2'b11;
        end else begin
            res_sync_q <= {res_sync_q[0], st7789_RES};
        end
    end

    assign srst = w_rst | ~res_sync_q[1];

    m_st7789_rx_deser #(
        .IDLE_CYC (IDLE_CYC)
    ) u_deser (
        .clk_i      (w_clk),
        .rst_i      (w_rst),
        .srst_i     (srst),
        .scl_i      (st7789_SCL),
        .sda_i      (st7789_SDA),
        .dc_i       (st7789_DC),
        .byte_vld_o (rx_vld),
        .byte_o     (rx_byte),
        .dc_o       (rx_dc),
        .trunc_o    (rx_trunc)
    );

    // par_q holds the first three params {S_hi, S_lo, E_hi}; the fourth arrives
    // as rx_byte. An inverted window collapses to a single line at S.
    assign win_s     = par_q[23:8];
    assign win_e_raw = {par_q[7:0], rx_byte};
    assign win_e     = (win_e_raw < win_s) ? win_s : win_e_raw;

    always_comb begin
        state_d   = state_q;
        pidx_d    = pidx_q;
        par_d     = par_q;
        xs_d      = xs_q;
        xe_d      = xe_q;
        ys_d      = ys_q;
        ye_d      = ye_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        hi_d      = hi_q;
        cmd_vld_d = 1'b0;
        cmd_d     = cmd_q;
        we_d      = 1'b0;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        fd_d      = 1'b0;
        err_d     = err_q | rx_trunc;

        if (rx_vld) begin
            if (!rx_dc) begin
                cmd_vld_d = 1'b1;
                cmd_d     = rx_byte;
                pidx_d    = 2'd0;
                case (rx_byte)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_PIX_HI;
                        cx_d    = xs_q;
                        cy_d    = ys_q;
                    end
                    CMD_SWRESET: begin
                        state_d = ST_CMD;
                        xs_d    = 16'h0000;
                        xe_d    = XE_RST;
                        ys_d    = 16'h0000;
                        ye_d    = YE_RST;
                        cx_d    = 16'h0000;
                        cy_d    = 16'h0000;
                    end
                    default: state_d = ST_SKIP;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (pidx_q == 2'd3) begin
                            if (state_q == ST_CASET) begin
                                xs_d = win_s;
                                xe_d = win_e;
                            end else begin
                                ys_d = win_s;
                                ye_d = win_e;
                            end
                            state_d = ST_SKIP;
                        end else begin
                            par_d  = {par_q[15:0], rx_byte};
                            pidx_d = pidx_q + 2'd1;
                        end
                    end
                    ST_PIX_HI: begin
                        hi_d    = rx_byte;
                        state_d = ST_PIX_LO;
                    end
                    ST_PIX_LO: begin
                        we_d    = (cx_q < W16) && (cy_q < H16);
                        wadr_d  = {cy_q[7:0], cx_q[7:0]};
                        wdata_d = {hi_q, rx_byte};
                        fd_d    = (cx_q == xe_q) && (cy_q == ye_q);
                        if (cx_q == xe_q) begin
                            cx_d = xs_q;
                            cy_d = (cy_q == ye_q) ? ys_q : cy_q + 16'd1;
                        end else begin
                            cx_d = cx_q + 16'd1;
                        end
                        state_d = ST_PIX_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (srst) begin
            state_q   <= ST_CMD;
            pidx_q    <= 2'd0;
            par_q     <= 24'h000000;
            xs_q      <= 16'h0000;
            xe_q      <= XE_RST;
            ys_q      <= 16'h0000;
            ye_q      <= YE_RST;
            cx_q      <= 16'h0000;
            cy_q      <= 16'h0000;
            hi_q      <= 8'h00;
            cmd_vld_q <= 1'b0;
            cmd_q     <= 8'h00;
            we_q      <= 1'b0;
            wadr_q    <= 16'h0000;
            wdata_q   <= 16'h0000;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pidx_q    <= pidx_d;
            par_q     <= par_d;
            xs_q      <= xs_d;
            xe_q      <= xe_d;
            ys_q      <= ys_d;
            ye_q      <= ye_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            hi_q      <= hi_d;
            cmd_vld_q <= cmd_vld_d;
            cmd_q     <= cmd_d;
            we_q      <= we_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            fd_q      <= fd_d;
        end
    end

    // The error flag survives a display reset; only the system reset clears it.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign w_cmd_vld    = cmd_vld_q;
    assign w_cmd        = cmd_q;
    assign w_we         = we_q;
    assign w_wadr       = wadr_q;
    assign w_wdata      = wdata_q;
    assign w_frame_done = fd_q;
    assign w_err        = err_q;

endmodule

// File: tb/tb_m_st7789_rx.sv
module tb_m_st7789_rx;

    localparam int WIDTH  = 240;
    localparam int HEIGHT = 240;

    logic        w_clk = 1'b0;
    logic        w_rst = 1'b1;
    logic        scl   = 1'b1;
    logic        sda   = 1'b0;
    logic        dc    = 1'b0;
    logic        res   = 1'b1;
    logic        w_cmd_vld;
    logic [7:0]  w_cmd;
    logic        w_we;
    logic [15:0] w_wadr;
    logic [15:0] w_wdata;
    logic        w_frame_done;
    logic        w_err;

    always #5 w_clk = ~w_clk;

    m_st7789_rx #(
        .WIDTH    (WIDTH),
        .HEIGHT   (HEIGHT),
        .IDLE_CYC (3)
    ) dut (
        .w_clk        (w_clk),
        .w_rst        (w_rst),
        .st7789_SCL   (scl),
        .st7789_SDA   (sda),
        .st7789_DC    (dc),
        .st7789_RES   (res),
        .w_cmd_vld    (w_cmd_vld),
        .w_cmd        (w_cmd),
        .w_we         (w_we),
        .w_wadr       (w_wadr),
        .w_wdata      (w_wdata),
        .w_frame_done (w_frame_done),
        .w_err        (w_err)
    );

    typedef struct packed {
        logic        we;
        logic [15:0] adr;
        logic [15:0] data;
        logic        fd;
    } ev_t;

    ev_t        exp_ev[$];
    logic [7:0] exp_cmd[$];
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Reference model state: window and cursor in screen coordinates.
    int mxs, mxe, mys, mye, mcx, mcy;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: every command pulse and every pixel slot event is matched
    // against the oldest expectation.
    ev_t        mev;
    logic [7:0] mcmd;
    always @(negedge w_clk) begin
        if (mon_en) begin
            if (w_cmd_vld) begin
                checks++;
                if (exp_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_unexpected actual=%h required=none", w_cmd);
                end else begin
                    mcmd = exp_cmd.pop_front();
                    if (w_cmd !== mcmd) begin
                        errors++;
                        $display("FAIL cmd actual=%h required=%h", w_cmd, mcmd);
                    end
                end
            end
            if (w_we || w_frame_done) begin
                checks++;
                if (exp_ev.size() == 0) begin
                    errors++;
                    $display("FAIL pix_unexpected actual we=%b adr=%h fd=%b required=none",
                             w_we, w_wadr, w_frame_done);
                end else begin
                    mev = exp_ev.pop_front();
                    if (w_we !== mev.we || w_frame_done !== mev.fd ||
                        (mev.we && (w_wadr !== mev.adr || w_wdata !== mev.data))) begin
                        errors++;
                        $display("FAIL pix actual we=%b adr=%h data=%h fd=%b required we=%b adr=%h data=%h fd=%b",
                                 w_we, w_wadr, w_wdata, w_frame_done, mev.we, mev.adr, mev.data, mev.fd);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Mode 2 bit timing: SDA changes with SCL rising, receiver samples on fall.
    task automatic send_bits(input logic dcv, input logic [7:0] b, input int nbits);
        @(posedge w_clk);
        #2;
        dc = dcv;
        for (int i = 7; i > 7 - nbits; i--) begin
            sda = b[i];
            #10 scl = 1'b0;
            #20 scl = 1'b1;
        end
    endtask

    task automatic send_byte(input logic dcv, input logic [7:0] b);
        send_bits(dcv, b, 8);
    endtask

    task automatic m_reset_window();
        mxs = 0; mxe = WIDTH - 1; mys = 0; mye = HEIGHT - 1; mcx = 0; mcy = 0;
    endtask

    task automatic do_cmd(input logic [7:0] op);
        exp_cmd.push_back(op);
        send_byte(1'b0, op);
    endtask

    task automatic do_win(input logic [7:0] op, input int s, input int e);
        logic [15:0] s16, e16;
        s16 = 16'(s);
        e16 = 16'(e);
        do_cmd(op);
        send_byte(1'b1, s16[15:8]);
        send_byte(1'b1, s16[7:0]);
        send_byte(1'b1, e16[15:8]);
        send_byte(1'b1, e16[7:0]);
        if (op == 8'h2A) begin
            mxs = s; mxe = (e < s) ? s : e;
        end else begin
            mys = s; mye = (e < s) ? s : e;
        end
    endtask

    task automatic ramwr_start();
        do_cmd(8'h2C);
        mcx = mxs;
        mcy = mys;
    endtask

    task automatic pixel(input logic [15:0] d);
        ev_t ev;
        bit  inb, fd;
        inb = (mcx < WIDTH) && (mcy < HEIGHT);
        fd  = (mcx == mxe) && (mcy == mye);
        ev.we   = inb;
        ev.adr  = {8'(mcy), 8'(mcx)};
        ev.data = d;
        ev.fd   = fd;
        if (inb || fd) exp_ev.push_back(ev);
        if (mcx == mxe) begin
            mcx = mxs;
            mcy = (mcy == mye) ? mys : mcy + 1;
        end else begin
            mcx = mcx + 1;
        end
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
    endtask

    task automatic ramwr_rand(input int n);
        ramwr_start();
        for (int i = 0; i < n; i++) pixel(16'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_ev.size() != 0) && n < 400) begin
            @(posedge w_clk);
            n++;
        end
        repeat (8) @(posedge w_clk);
        chk("drain_cmd_left", 32'(exp_cmd.size()), 32'd0);
        chk("drain_pix_left", 32'(exp_ev.size()), 32'd0);
    endtask

    initial begin
        m_reset_window();
        repeat (5) @(posedge w_clk);
        @(negedge w_clk);
        chk("rst_we", {31'd0, w_we}, 32'd0);
        chk("rst_cmd_vld", {31'd0, w_cmd_vld}, 32'd0);
        chk("rst_cmd", {24'd0, w_cmd}, 32'd0);
        chk("rst_err", {31'd0, w_err}, 32'd0);
        chk("rst_fd", {31'd0, w_frame_done}, 32'd0);
        @(posedge w_clk);
        #1 w_rst = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(posedge w_clk);

        // Full window, two pixels.
        do_win(8'h2A, 0, 8'hEF);
        do_win(8'h2B, 0, 8'hEF);
        ramwr_start();
        pixel(16'hF800);
        pixel(16'h07E0);
        drain();

        // 2x2 window wrap with frame_done on the 4th pixel.
        do_win(8'h2A, 0, 1);
        do_win(8'h2B, 0, 1);
        ramwr_rand(5);
        drain();

        // XE beyond WIDTH: x=240 slot suppressed, then wrap to row 1.
        do_win(8'h2A, 0, 8'hF0);
        do_win(8'h2B, 0, 8'hEF);
        ramwr_rand(242);
        drain();

        // YE beyond HEIGHT: frame_done on a suppressed slot.
        do_win(8'h2B, 239, 240);
        do_win(8'h2A, 0, 1);
        ramwr_rand(4);
        drain();

        // Aborted CASET leaves the window unchanged.
        do_win(8'h2A, 0, 8'hEF);
        do_win(8'h2B, 0, 8'hEF);
        do_cmd(8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h05);
        ramwr_rand(2);
        drain();

        // Inverted window (S>E) plus an ignored 5th param.
        do_win(8'h2A, 5, 2);
        send_byte(1'b1, 8'h77);
        do_win(8'h2B, 3, 4);
        ramwr_rand(3);
        // Unknown command with params, then a command mid-pixel drops the hi byte.
        do_cmd(8'h3A);
        send_byte(1'b1, 8'h55);
        send_byte(1'b1, 8'h66);
        ramwr_start();
        send_byte(1'b1, 8'hAB);
        ramwr_start();
        pixel(16'h1234);
        // Software reset restores the full window.
        do_cmd(8'h01);
        m_reset_window();
        ramwr_rand(2);
        drain();

        // Randomised windows near the origin and near the right edge.
        for (int it = 0; it < 6; it++) begin
            do_win(8'h2A, $urandom_range(0, 4), $urandom_range(0, 6));
            do_win(8'h2B, $urandom_range(0, 4), $urandom_range(0, 6));
            ramwr_rand($urandom_range(1, 10));
        end
        do_win(8'h2A, 237, 241);
        do_win(8'h2B, 10, 11);
        ramwr_rand(12);
        drain();

        // Partial byte, idle timeout, then a clean RAMWR.
        chk("err_before_trunc", {31'd0, w_err}, 32'd0);
        send_bits(1'b0, 8'hA5, 4);
        repeat (10) @(posedge w_clk);
        @(negedge w_clk);
        chk("err_after_trunc", {31'd0, w_err}, 32'd1);
        ramwr_rand(1);
        drain();
        chk("cmd_after_trunc", {24'd0, w_cmd}, 32'h2C);

        // Display reset mid-RAMWR with cursor at 0x0010.
        do_cmd(8'h01);
        m_reset_window();
        ramwr_rand(16);
        drain();
        @(posedge w_clk);
        #2 res = 1'b0;
        repeat (4) @(posedge w_clk);
        @(negedge w_clk);
        chk("res_cmd", {24'd0, w_cmd}, 32'd0);
        chk("res_err_kept", {31'd0, w_err}, 32'd1);
        #2 res = 1'b1;
        m_reset_window();
        repeat (6) @(posedge w_clk);
        ramwr_rand(1);
        drain();

        // System reset in the middle of a byte.
        send_bits(1'b1, 8'h3C, 4);
        @(posedge w_clk);
        #1 w_rst = 1'b1;
        repeat (2) @(posedge w_clk);
        @(negedge w_clk);
        chk("wrst_cmd", {24'd0, w_cmd}, 32'd0);
        chk("wrst_err", {31'd0, w_err}, 32'd0);
        chk("wrst_adr", {16'd0, w_wadr}, 32'd0);
        chk("wrst_data", {16'd0, w_wdata}, 32'd0);
        chk("wrst_we_fd", {30'd0, w_we, w_frame_done}, 32'd0);
        @(posedge w_clk);
        #1 w_rst = 1'b0;
        m_reset_window();
        repeat (4) @(posedge w_clk);
        do_win(8'h2A, 0, 1);
        do_win(8'h2B, 0, 1);
        ramwr_rand(4);
        drain();
        chk("err_after_wrst", {31'd0, w_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
